// File: rtl/alu_regfile_seq.sv
// alu_regfile_seq
//   Operand-supply and writeback sequencer for an external 8-bit combinational
//   ALU. Takes 3-operand instructions over valid/ready, reads operands from an
//   8x8 register file, drives the ALU from registers, and writes the result back.
//   A sticky carry flag is updated only by add (0000) and subtract (0001).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   instr_valid/ready instruction handshake; instr = {op, rd, rs, rt}
//   wr_en/addr/data   external register load, honoured only while idle
//   rd_addr/rd_data   combinational debug read port
//   alu_ctrl/x/y      registered ALU operands, held while idle
//   alu_out/carry     ALU result inputs
//   carry_flag        sticky arithmetic carry
//   busy              high in EXEC or WB
//   done              one-cycle pulse after writeback
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | accepting loads or a new instruction
// EXEC  | ALU operands stable, combinational ALU settling
// WB    | result written to R[rd], carry updated for add/sub

module alu_regfile_seq #(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [12:0]   instr,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [2:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] alu_x,
  output logic [DW-1:0] alu_y,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  output logic          carry_flag,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] regs [NREG];
  logic [2:0]    rd_q;
  logic          accept;

  logic [3:0] op;
  logic [2:0] rd, rs, rt;

  assign op = instr[12:9];
  assign rd = instr[8:6];
  assign rs = instr[5:3];
  assign rt = instr[2:0];

  // A pending load takes priority over an offered instruction.
  assign instr_ready = (state == IDLE) & ~wr_en;
  assign accept      = instr_ready & instr_valid;
  assign busy        = (state != IDLE);
  assign rd_data     = regs[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_ctrl   <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      rd_q       <= '0;
      carry_flag <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == WB);

      if (state == IDLE && wr_en) regs[wr_addr] <= wr_data;

      // Operands come from the register values before this edge, so rd==rs/rt
      // naturally uses the old value.
      if (accept) begin
        alu_ctrl <= op;
        alu_x    <= regs[rs];
        alu_y    <= regs[rt];
        rd_q     <= rd;
      end

      // alu_ctrl still holds the op of the instruction in flight; the ALU carry
      // is only meaningful for add/sub.
      if (state == WB) begin
        regs[rd_q] <= alu_out;
        if (alu_ctrl[3:1] == 3'b000) carry_flag <= alu_carry;
      end
    end
  end

endmodule

// File: doc/alu_regfile_seq.md
Name: alu_regfile_seq

Overview:
- Operand-supply and writeback sequencer directly upstream/downstream of the 8-bit ALU (4-bit ctrl, 8-bit x/y, 8-bit out, carry).
- Accepts 3-operand instructions over a valid/ready handshake and reads operands from an 8x8 register file.
- Drives ALU ctrl/x/y from registers, then writes the ALU result back into the register file.
- Keeps a sticky carry flag updated only by add/subtract.

Parameters:
- NREG, 8, number of registers; fixed at 8 (3-bit addresses).
- DW, 8, data width; must match the ALU.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  sequencer can accept an instruction this cycle
- instr  input  13  {op[12:9], rd[8:6], rs[5:3], rt[2:0]}
- wr_en  input  1  external register load (initialisation)
- wr_addr  input  3  external load address
- wr_data  input  8  external load data
- rd_addr  input  3  debug read address
- rd_data  output  8  R[rd_addr], combinational
- alu_ctrl  output  4  to ALU ctrl
- alu_x  output  8  to ALU x
- alu_y  output  8  to ALU y
- alu_out  input  8  from ALU out
- alu_carry  input  1  from ALU carry
- carry_flag  output  1  sticky arithmetic carry
- busy  output  1  high in EXEC or WB
- done  output  1  one-cycle pulse after writeback

Behaviour:
- Reset (async, immediate): state=IDLE; R[0..7]=0; alu_ctrl=0, alu_x=0, alu_y=0; carry_flag=0; done=0. Reset during EXEC/WB aborts the instruction: no writeback, no done.
- Outputs alu_ctrl/alu_x/alu_y are registered and hold their last value while IDLE.
- instr_ready = (state==IDLE) & ~wr_en.
- busy = (state!=IDLE).
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - If wr_en: R[wr_addr] <= wr_data; no instruction is accepted this cycle.
  - Else if instr_valid: capture rd. Load alu_ctrl<=op, alu_x<=R[rs], alu_y<=R[rt] using register values before this edge. Go to EXEC.
- EXEC: one settle cycle for the combinational ALU; no register changes. Go to WB.
- WB:
  - R[rd] <= alu_out.
  - If op==4'b0000 or op==4'b0001: carry_flag <= alu_carry. Otherwise carry_flag is unchanged, because the ALU's carry is stale for logic/shift ops.
  - done <= 1 for exactly the next cycle. Go to IDLE.
- Latency: handshake at edge N; write at edge N+2; done high during cycle N+2..N+3; instr_ready high again in that same cycle.
- Throughput: one instruction per 3 cycles; no pipelining, so no hazards. rd may equal rs and/or rt: the old value is used as the operand and the result overwrites it.
- wr_en and instr_valid both high in IDLE: the load wins, instr_ready=0, and the instruction stays pending (valid must be held per protocol).
- wr_en while busy is ignored (no write).
- Undefined ALU ops (1101-1111) are executed normally: the ALU returns 0, so R[rd] <= 0 and carry is unchanged.
- rd_data reflects register contents after the edge; no bypass of same-cycle writes.
- All widths 8 bits; no arithmetic is performed locally.

Test Plan:
- Reset mid-EXEC (after loading R1=0x55, issuing AND) -> R[*]=0, carry_flag=0, no done pulse, instr_ready=1 next cycle.
- Load R1=0x7F, R2=0x01; issue ADD rd=3 rs=1 rt=2 -> alu_x=0x7F, alu_y=0x01 one cycle after accept; R3=0x80, carry_flag=0, done exactly at accept+2 edges, busy high for 2 cycles.
- Load R4=0x80, R5=0x80; ADD rd=6 -> R6=0x00, carry_flag=1. Then AND rd=7 rs=4 rt=5 -> R7=0x80, carry_flag still 1.
- Load R0=0x00, R1=0x01; SUB rd=0 rs=0 rt=1 -> R0=0xFF (rd==rs overwrite), carry_flag=1. Then SUB rd=2 rs=1 rt=1 -> R2=0x00, carry_flag=0.
- Shift/compare: R1=0x03, R2=0x81; op 0111 rd=3 rs=1 rt=2 -> R3=0x08; op 1100 rd=4 rs=2 rt=2 -> R4=0x01; op 1111 -> R[rd]=0x00.
- Hold instr_valid with wr_en=1 for 2 cycles -> instr_ready=0 and no accept; the write lands. wr_en drops -> accept next edge using the newly written value. wr_en asserted during EXEC -> no register change.
